afifo_rd_stream: RTL and testbench



---
 rtl/afifo_pkg.sv | 13 +
 rtl/afifo_rd_stream_if.sv | 11 +
 rtl/afifo_rd_skid_buf.sv | 54 +++++
 rtl/afifo_rd_stream.sv | 97 +++++++++
 tb/tb_afifo_rd_stream.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/afifo_pkg.sv
// Shared types and constants for the async FIFO read-side stream adapter.
package afifo_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } rd_state_e;

    // rclk cycles between a pop strobe and its word appearing on rdata
    localparam int AFIFO_RD_LATENCY = 1;

endpackage

// File: rtl/afifo_rd_stream_if.sv
// Valid/ready stream carrying words drained from the async FIFO.
interface afifo_rd_stream_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (output m_valid, output m_data, input m_ready);
    modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/afifo_rd_skid_buf.sv
// Circular elastic buffer: registered storage, push/pop pointers and occupancy.
module afifo_rd_skid_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    push_i,
    input  logic [DATA_WIDTH-1:0]   push_data_i,
    input  logic                    pop_i,
    output logic [$clog2(DEPTH):0]  occ_o,
    output logic [DATA_WIDTH-1:0]   data_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push_i);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        occ_d    = occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is cleared on reset so the output word reads zero while empty
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                mem_q[gi] <= '0;
            end else if (push_i && (wr_ptr_q == PTR_W'(gi))) begin
                mem_q[gi] <= push_data_i;
            end
        end
    end

    assign occ_o  = occ_q;
    assign data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/afifo_rd_stream.sv
// Async FIFO read-side consumer: credit-gated pops into an elastic buffer, drained as a stream.
module afifo_rd_stream
    import afifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_DEPTH  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                   rclk,
    input  logic                   rrst_n,
    input  logic                   enable,
    input  logic                   rempty,
    output logic                   rinc,
    input  logic [DATA_WIDTH-1:0]  rdata,
    afifo_rd_stream_if.master      m_axis,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   rd_count
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    rd_state_e                    state_q, state_d;
    logic                         busy_q;
    logic [CNT_WIDTH-1:0]         rd_count_q;
    logic [AFIFO_RD_LATENCY-1:0]  pipe_q;
    logic [OCC_W-1:0]             occ;
    logic [OCC_W-1:0]             inflight_cnt;
    logic [OCC_W:0]               credit_used;
    logic [DATA_WIDTH-1:0]        buf_data;
    logic                         capture;
    logic                         xfer;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < AFIFO_RD_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + OCC_W'(pipe_q[i]);
        end
    end

    // Credits count words already buffered plus words still on their way from the FIFO
    assign credit_used = {1'b0, occ} + {1'b0, inflight_cnt};
    assign rinc        = (state_q == ACTIVE) && !rempty
                         && (credit_used < (OCC_W + 1)'(BUF_DEPTH));
    assign capture     = pipe_q[AFIFO_RD_LATENCY-1];
    assign xfer        = m_axis.m_valid && m_axis.m_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = ACTIVE;
            ACTIVE:  if (!enable) state_d = DRAIN;
            DRAIN: begin
                if (enable) begin
                    state_d = ACTIVE;
                end else if ((inflight_cnt == '0) && (occ == '0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            pipe_q     <= '0;
            rd_count_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != IDLE);
            pipe_q  <= AFIFO_RD_LATENCY'({pipe_q, rinc});
            if (rinc) begin
                rd_count_q <= rd_count_q + CNT_WIDTH'(1);
            end
        end
    end

    afifo_rd_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk_i       (rclk),
        .rst_ni      (rrst_n),
        .push_i      (capture),
        .push_data_i (rdata),
        .pop_i       (xfer),
        .occ_o       (occ),
        .data_o      (buf_data)
    );

    assign m_axis.m_valid = (occ != '0);
    assign m_axis.m_data  = buf_data;
    assign busy           = busy_q;
    assign rd_count       = rd_count_q;

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Directed bench for afifo_rd_stream: FIFO model, write-order scoreboard and stream monitor.
module tb_afifo_rd_stream;
    localparam int DW = 32;

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          enable = 1'b0;
    logic          rempty = 1'b1;
    logic          force_empty = 1'b0;
    logic          m_ready = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          rinc, rinc2, busy, busy2;
    logic [31:0]   rd_count;
    logic [3:0]    rd_count2;

    always #5 rclk = ~rclk;

    afifo_rd_stream_if #(.DATA_WIDTH(DW)) s_if ();
    afifo_rd_stream_if #(.DATA_WIDTH(DW)) s2_if ();
    assign s_if.m_ready  = m_ready;
    assign s2_if.m_ready = m_ready;

    afifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(4), .CNT_WIDTH(32)) dut (
        .rclk(rclk), .rrst_n(rrst_n), .enable(enable), .rempty(rempty), .rinc(rinc),
        .rdata(rdata), .m_axis(s_if), .busy(busy), .rd_count(rd_count)
    );

    // Narrow-counter build fed by the same stimulus, used for the wrap check
    afifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(4), .CNT_WIDTH(4)) dut_c4 (
        .rclk(rclk), .rrst_n(rrst_n), .enable(enable), .rempty(rempty), .rinc(rinc2),
        .rdata(rdata), .m_axis(s2_if), .busy(busy2), .rd_count(rd_count2)
    );

    logic [DW-1:0] fifo  [$];
    logic [DW-1:0] exp_q [$];
    int checks = 0, failures = 0;
    int cyc = 0, pop_cnt = 0, xfer_cnt = 0;
    int first_rinc = -1, last_rinc = -1, first_valid = -1, last_valid = -1;
    int base_p, base_x;
    bit watch = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // FIFO read port: data appears one rclk after the pop strobe
    always @(posedge rclk) begin
        if (rinc) begin
            if (fifo.size() != 0) rdata <= fifo.pop_front();
            else                  rdata <= '0;
        end
    end

    task automatic upd_empty();
        rempty = force_empty || (fifo.size() == 0);
    endtask

    task automatic step();
        @(negedge rclk);
        upd_empty();
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        repeat (3) step();
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic go_idle(input string name);
        enable = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 50 && busy; i++) step();
        check(name, 64'(busy), 64'd0);
    endtask

    // Monitor: samples just after the falling edge, i.e. what the next rising edge will see
    initial begin
        forever begin
            @(negedge rclk);
            #1;
            cyc++;
            if (rrst_n) begin
                if (rempty) check("no_pop_when_empty", 64'(rinc), 64'd0);
                if (watch)  check("no_pop_after_enable_low", 64'(rinc), 64'd0);
                if (rinc) begin
                    pop_cnt++;
                    if (first_rinc < 0) first_rinc = cyc;
                    last_rinc = cyc;
                end
                if (s_if.m_valid) begin
                    if (first_valid < 0) first_valid = cyc;
                    last_valid = cyc;
                end
                if (s_if.m_valid && m_ready) begin
                    xfer_cnt++;
                    $display("xfer cyc=%0d data=0x%0h", cyc, s_if.m_data);
                    if (exp_q.size() == 0) check("stream_unexpected_word", 64'(s_if.m_data), 64'hDEAD_0000);
                    else check("stream_data", 64'(s_if.m_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (2) step();
        #1;
        check("rst_rinc", 64'(rinc), 64'd0);
        check("rst_m_valid", 64'(s_if.m_valid), 64'd0);
        check("rst_m_data", 64'(s_if.m_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rd_count", 64'(rd_count), 64'd0);
        step();
        rrst_n = 1'b1;
        step();

        // Five preloaded words at full throughput
        base_p = pop_cnt; base_x = xfer_cnt;
        for (int i = 0; i < 5; i++) push_word(32'hA0 + 32'(i));
        upd_empty();
        m_ready = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 40 && (xfer_cnt - base_x) < 5; i++) step();
        repeat (2) step();
        check("p1_pops", 64'(pop_cnt - base_p), 64'd5);
        check("p1_rinc_consecutive", 64'(last_rinc - first_rinc), 64'd4);
        check("p1_first_valid_latency", 64'(first_valid - first_rinc), 64'd2);
        check("p1_valid_consecutive", 64'(last_valid - first_valid), 64'd4);
        check("p1_rd_count", 64'(rd_count), 64'd5);
        go_idle("p1_idle");

        // Backpressure with ten words waiting
        m_ready = 1'b0;
        base_p = pop_cnt;
        for (int i = 0; i < 10; i++) push_word(32'hB0 + 32'(i));
        upd_empty();
        enable = 1'b1;
        repeat (12) step();
        check("p2_pops_limited", 64'(pop_cnt - base_p), 64'd4);
        check("p2_rinc_stalled", 64'(rinc), 64'd0);
        check("p2_valid_held", 64'(s_if.m_valid), 64'd1);
        check("p2_data_held", 64'(s_if.m_data), 64'hB0);
        m_ready = 1'b1;
        drain("p2_all_delivered", 80);
        check("p2_fifo_empty", 64'(fifo.size()), 64'd0);
        go_idle("p2_idle");

        // Toggling empty flag with random backpressure
        for (int i = 0; i < 20; i++) push_word(32'hC0 + 32'(i));
        upd_empty();
        enable = 1'b1;
        for (int i = 0; i < 80; i++) begin
            step();
            force_empty = i[0];
            m_ready = 1'($urandom_range(0, 1));
            upd_empty();
        end
        force_empty = 1'b0;
        m_ready = 1'b1;
        upd_empty();
        drain("p3_all_delivered", 120);
        go_idle("p3_idle");

        // Enable dropped with two words buffered and one in flight
        m_ready = 1'b0;
        base_p = pop_cnt;
        for (int i = 0; i < 3; i++) push_word(32'hD0 + 32'(i));
        upd_empty();
        enable = 1'b1;
        for (int i = 0; i < 20 && (pop_cnt - base_p) < 3; i++) step();
        enable = 1'b0;
        step();
        push_word(32'hE0);
        push_word(32'hE1);
        upd_empty();
        watch = 1'b1;
        base_x = xfer_cnt;
        repeat (3) step();
        check("p4_busy_while_drain", 64'(busy), 64'd1);
        check("p4_head_held", 64'(s_if.m_data), 64'hD0);
        m_ready = 1'b1;
        for (int i = 0; i < 30 && busy; i++) step();
        check("p4_returned_idle", 64'(busy), 64'd0);
        check("p4_words_drained", 64'(xfer_cnt - base_x), 64'd3);
        watch = 1'b0;

        // Async reset with three words buffered and one in flight
        m_ready = 1'b0;
        base_p = pop_cnt;
        for (int i = 0; i < 4; i++) push_word(32'hF0 + 32'(i));
        upd_empty();
        enable = 1'b1;
        for (int i = 0; i < 20 && (pop_cnt - base_p) < 4; i++) step();
        rrst_n = 1'b0;
        #1;
        check("p5_rst_m_valid", 64'(s_if.m_valid), 64'd0);
        check("p5_rst_rd_count", 64'(rd_count), 64'd0);
        check("p5_rst_rinc", 64'(rinc), 64'd0);
        check("p5_rst_busy", 64'(busy), 64'd0);
        repeat (4) void'(exp_q.pop_front());
        step();
        rrst_n = 1'b1;
        base_p = pop_cnt;
        m_ready = 1'b1;
        drain("p5_resume_from_head", 40);
        check("p5_resume_pops", 64'(pop_cnt - base_p), 64'd2);
        go_idle("p5_idle");

        // Counter wrap on the 4-bit build
        rrst_n = 1'b0;
        step();
        rrst_n = 1'b1;
        step();
        for (int i = 0; i < 17; i++) push_word(32'h100 + 32'(i));
        upd_empty();
        m_ready = 1'b1;
        enable = 1'b1;
        drain("p6_all_delivered", 80);
        check("p6_rd_count_32", 64'(rd_count), 64'd17);
        check("p6_rd_count_wrap", 64'(rd_count2), 64'd1);
        go_idle("p6_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
